// File: rtl/gamestate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gamestate_ctrl : MENU/RUN/PAUSE/OVER game-flow FSM with round timer,        |
// |                  lives and level counters.  Rev 1.0                         |
// +----------------------------------------------------------------------------+
module gamestate_ctrl #(
   parameter  int TICK_DIV    = 100_000_000,
   parameter  int ROUND_TICKS = 60,
   parameter  int LIVES       = 3,
   parameter  int MAX_LEVEL   = 9,
   localparam int TIME_W      = $clog2(ROUND_TICKS + 1),
   localparam int LIFE_W      = $clog2(LIVES + 1),
   localparam int LVL_W       = $clog2(MAX_LEVEL + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_start,
   input  logic              btn_pause,
   input  logic              btn_menu,
   input  logic              hit,
   input  logic              level_done,
   output logic              gamemenu,
   output logic              gamerun,
   output logic              gamepause,
   output logic              gameover,
   output logic              tick,
   output logic [TIME_W-1:0] time_left,
   output logic [LIFE_W-1:0] lives,
   output logic [LVL_W-1:0]  level
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [TIME_W-1:0] TIME_RELOAD = TIME_W'(ROUND_TICKS);
   localparam logic [TIME_W-1:0] TIME_ONE    = TIME_W'(1);
   localparam logic [LIFE_W-1:0] LIFE_INIT   = LIFE_W'(LIVES);
   localparam logic [LIFE_W-1:0] LIFE_ONE    = LIFE_W'(1);
   localparam logic [LVL_W-1:0]  LVL_MAX     = LVL_W'(MAX_LEVEL);
   localparam logic [LVL_W-1:0]  LVL_ONE     = LVL_W'(1);

   typedef enum logic [1:0] {
      S_MENU  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [TIME_W-1:0]  time_left_q, time_left_d;
   logic [LIFE_W-1:0]  lives_q, lives_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               btn_start_q, btn_start_d;
   logic               btn_pause_q, btn_pause_d;
   logic               btn_menu_q, btn_menu_d;
   logic               press_start, press_pause, press_menu;

   assign tick      = (state_q == S_RUN) && (tick_cnt_q == CNT_MAX);
   assign gamemenu  = (state_q == S_MENU);
   assign gamerun   = (state_q == S_RUN);
   assign gamepause = (state_q == S_PAUSE);
   assign gameover  = (state_q == S_OVER);
   assign time_left = time_left_q;
   assign lives     = lives_q;
   assign level     = level_q;

   always_comb begin
      btn_start_d = btn_start;
      btn_pause_d = btn_pause;
      btn_menu_d  = btn_menu;
      press_start = btn_start & ~btn_start_q;
      press_pause = btn_pause & ~btn_pause_q;
      press_menu  = btn_menu & ~btn_menu_q;
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      time_left_d = time_left_q;
      lives_d     = lives_q;
      level_d     = level_q;

      case (state_q)
         S_MENU: begin
            if (press_start) begin
               state_d     = S_RUN;
               tick_cnt_d  = '0;
               time_left_d = TIME_RELOAD;
               lives_d     = LIFE_INIT;
               level_d     = LVL_ONE;
            end
         end
         S_RUN: begin
            if (press_menu) begin
               state_d = S_MENU;
            end else if (press_pause) begin
               state_d = S_PAUSE;
            end else begin
               tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_ONE;
               if (hit && (lives_q == LIFE_ONE)) begin
                  lives_d = '0;
                  state_d = S_OVER;
               end else if (tick && (time_left_q == TIME_ONE)) begin
                  time_left_d = '0;
                  state_d     = S_OVER;
               end else begin
                  if (hit && (lives_q != '0))
                     lives_d = lives_q - LIFE_ONE;
                  if (tick && (time_left_q != '0))
                     time_left_d = time_left_q - TIME_ONE;
                  // a finished level restarts the round, overriding this cycle's tick
                  if (level_done) begin
                     level_d     = (level_q >= LVL_MAX) ? LVL_MAX : level_q + LVL_ONE;
                     time_left_d = TIME_RELOAD;
                     tick_cnt_d  = '0;
                  end
               end
            end
         end
         S_PAUSE: begin
            if (press_menu)
               state_d = S_MENU;
            else if (press_start || press_pause)
               state_d = S_RUN;
         end
         S_OVER: begin
            if (press_start || press_menu)
               state_d = S_MENU;
         end
         default: state_d = S_MENU;
      endcase
   end

   // button history loads 1 so a button held through reset never fires on release of reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_MENU;
         tick_cnt_q  <= '0;
         time_left_q <= '0;
         lives_q     <= '0;
         level_q     <= '0;
         btn_start_q <= 1'b1;
         btn_pause_q <= 1'b1;
         btn_menu_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         time_left_q <= time_left_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         btn_start_q <= btn_start_d;
         btn_pause_q <= btn_pause_d;
         btn_menu_q  <= btn_menu_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gamestate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gamestate_ctrl : directed vector bench for gamestate_ctrl.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module tb_gamestate_ctrl;

   localparam logic [3:0] FM = 4'b1000;
   localparam logic [3:0] FR = 4'b0100;
   localparam logic [3:0] FP = 4'b0010;
   localparam logic [3:0] FO = 4'b0001;

   logic       clk = 1'b0;
   logic       reset, btn_start, btn_pause, btn_menu, hit, level_done;
   logic       gamemenu, gamerun, gamepause, gameover, tick;
   logic [1:0] time_left, lives, level;

   int checks = 0;
   int errors = 0;

   // input field order: {reset, btn_start, btn_pause, btn_menu, hit, level_done}
   typedef struct {
      logic [5:0] in;
      logic [3:0] flags;
      logic       tk;
      logic [1:0] tl;
      logic [1:0] lv;
      logic [1:0] lvl;
   } vec_t;

   vec_t vecs[$];

   gamestate_ctrl #(
      .TICK_DIV   (4),
      .ROUND_TICKS(3),
      .LIVES      (2),
      .MAX_LEVEL  (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_start (btn_start),
      .btn_pause (btn_pause),
      .btn_menu  (btn_menu),
      .hit       (hit),
      .level_done(level_done),
      .gamemenu  (gamemenu),
      .gamerun   (gamerun),
      .gamepause (gamepause),
      .gameover  (gameover),
      .tick      (tick),
      .time_left (time_left),
      .lives     (lives),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic add(input logic [5:0] in, input logic [3:0] f, input logic t,
                      input logic [1:0] tl, input logic [1:0] lv, input logic [1:0] lvl);
      vec_t v;
      v.in = in; v.flags = f; v.tk = t; v.tl = tl; v.lv = lv; v.lvl = lvl;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic [5:0] in);
      {reset, btn_start, btn_pause, btn_menu, hit, level_done} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] f, input logic t,
                             input logic [1:0] tl, input logic [1:0] lv, input logic [1:0] lvl);
      logic [10:0] got, exp;
      got = {gamemenu, gamerun, gamepause, gameover, tick, time_left, lives, level};
      exp = {f, t, tl, lv, lvl};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got flags=%b tick=%b time_left=%0d lives=%0d level=%0d, expected flags=%b tick=%b time_left=%0d lives=%0d level=%0d",
                  name, got[10:7], got[6], got[5:4], got[3:2], got[1:0], f, t, tl, lv, lvl);
      end
   endtask

   task automatic step(input string name, input logic [5:0] in, input logic [3:0] f, input logic t,
                       input logic [1:0] tl, input logic [1:0] lv, input logic [1:0] lvl);
      apply(in);
      expect_out(name, f, t, tl, lv, lvl);
   endtask

   initial begin
      {reset, btn_start, btn_pause, btn_menu, hit, level_done} = 6'b010000;

      // reset with start held, then first start press
      add(6'b010000, FM, 0, 0, 0, 0);
      add(6'b010000, FM, 0, 0, 0, 0);
      add(6'b110000, FM, 0, 0, 0, 0);
      add(6'b110000, FM, 0, 0, 0, 0);
      add(6'b100000, FM, 0, 0, 0, 0);
      add(6'b110000, FR, 0, 3, 2, 1);
      // twelve idle RUN cycles: round timer expiry
      add(6'b110000, FR, 0, 3, 2, 1);
      add(6'b100000, FR, 0, 3, 2, 1);
      add(6'b100000, FR, 1, 3, 2, 1);
      add(6'b100000, FR, 0, 2, 2, 1);
      add(6'b100000, FR, 0, 2, 2, 1);
      add(6'b100000, FR, 0, 2, 2, 1);
      add(6'b100000, FR, 1, 2, 2, 1);
      add(6'b100000, FR, 0, 1, 2, 1);
      add(6'b100000, FR, 0, 1, 2, 1);
      add(6'b100000, FR, 0, 1, 2, 1);
      add(6'b100000, FR, 1, 1, 2, 1);
      add(6'b100000, FO, 0, 0, 2, 1);
      add(6'b110000, FM, 0, 0, 2, 1);
      add(6'b100000, FM, 0, 0, 2, 1);
      add(6'b110000, FR, 0, 3, 2, 1);
      // two hits end the game; restart restores lives
      add(6'b100010, FR, 0, 3, 1, 1);
      add(6'b100000, FR, 0, 3, 1, 1);
      add(6'b100010, FO, 0, 3, 0, 1);
      add(6'b110000, FM, 0, 3, 0, 1);
      add(6'b100000, FM, 0, 3, 0, 1);
      add(6'b110000, FR, 0, 3, 2, 1);
      // level progression, hit+level_done together, saturation, reload vs tick
      add(6'b100001, FR, 0, 3, 2, 2);
      add(6'b100011, FR, 0, 3, 1, 3);
      add(6'b100000, FR, 0, 3, 1, 3);
      add(6'b100000, FR, 0, 3, 1, 3);
      add(6'b100000, FR, 1, 3, 1, 3);
      add(6'b100001, FR, 0, 3, 1, 3);
      add(6'b100001, FR, 0, 3, 1, 3);
      add(6'b100000, FR, 0, 3, 1, 3);
      add(6'b100000, FR, 0, 3, 1, 3);
      add(6'b100000, FR, 1, 3, 1, 3);
      add(6'b100000, FR, 0, 2, 1, 3);
      add(6'b100001, FR, 0, 3, 1, 3);
      // menu+pause together; inputs ignored in MENU
      add(6'b101100, FM, 0, 3, 1, 3);
      add(6'b100000, FM, 0, 3, 1, 3);
      add(6'b101000, FM, 0, 3, 1, 3);
      add(6'b100010, FM, 0, 3, 1, 3);
      add(6'b110000, FR, 0, 3, 2, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].in);
         expect_out($sformatf("vec%0d", i), vecs[i].flags, vecs[i].tk,
                    vecs[i].tl, vecs[i].lv, vecs[i].lvl);
      end

      // pause after six RUN cycles: tick counter and timer freeze
      step("idle1", 6'b100000, FR, 0, 3, 2, 1);
      step("idle2", 6'b100000, FR, 0, 3, 2, 1);
      step("idle3", 6'b100000, FR, 1, 3, 2, 1);
      step("idle4", 6'b100000, FR, 0, 2, 2, 1);
      step("idle5", 6'b100000, FR, 0, 2, 2, 1);
      step("idle6", 6'b100000, FR, 0, 2, 2, 1);
      step("pause_in", 6'b101000, FP, 0, 2, 2, 1);
      for (int i = 0; i < 20; i++)
         step($sformatf("paused%0d", i), 6'b100000, FP, 0, 2, 2, 1);
      step("resume", 6'b101000, FR, 0, 2, 2, 1);
      step("resume_tick", 6'b100000, FR, 1, 2, 2, 1);
      step("resume_dec", 6'b100000, FR, 0, 1, 2, 1);
      step("pause2", 6'b101000, FP, 0, 1, 2, 1);
      step("pause2_hold", 6'b100000, FP, 0, 1, 2, 1);
      step("start_resume", 6'b110000, FR, 0, 1, 2, 1);
      step("run_again", 6'b100000, FR, 0, 1, 2, 1);
      step("pause3", 6'b101000, FP, 0, 1, 2, 1);
      step("pause3_hold", 6'b100000, FP, 0, 1, 2, 1);
      step("pause_menu", 6'b100100, FM, 0, 1, 2, 1);

      // reset mid-game with buttons held
      step("restart", 6'b110000, FR, 0, 3, 2, 1);
      step("restart_hit", 6'b100010, FR, 0, 3, 1, 1);
      step("midreset", 6'b011000, FM, 0, 0, 0, 0);
      step("held_start", 6'b110000, FM, 0, 0, 0, 0);
      step("release", 6'b100000, FM, 0, 0, 0, 0);
      step("fresh_start", 6'b110000, FR, 0, 3, 2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
